// File: rtl/vga_rx.sv
// vga_rx: sink-side VGA timing recovery and pixel capture.
//
// Samples the VGA output-stage signals in the clk domain, detects pixel
// strobes (rising vga_clk), rebuilds x/y coordinates from sync and blank
// edges, and emits a pixel stream with frame/line markers once the source
// has been seen to start a frame. Active geometry is measured per line and
// per frame; a SEARCH -> TRACK -> LOCKED machine reports lock.
//
// Ports:
//   clk, reset           system clock, async active-high reset
//   vga_clk              pixel clock (rising edge = one pixel strobe)
//   vga_hs, vga_vs       active-low syncs
//   vga_blank_n          high during active video
//   vga_r/g/b            pixel colour
//   pix_valid/data/x/y   captured pixel, one-cycle pulse
//   pix_sof, pix_eol     frame start (0,0) / last pixel of line markers
//   locked               high in LOCKED
//   line_px, frame_lines geometry of last completed line / frame
//   err_cnt              saturating count of LOCKED -> SEARCH drops
module vga_rx #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int WDOG_CYCLES = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_clk,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        locked,
  output logic [10:0] line_px,
  output logic [9:0]  frame_lines,
  output logic [7:0]  err_cnt
);

  localparam int WW = $clog2(WDOG_CYCLES);

  typedef struct packed {
    logic        pclk;
    logic        hs;
    logic        vs;
    logic        bl;
    logic [23:0] rgb;
  } smp_t;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  smp_t          s1;
  logic          s2_pclk;   // only the pixel clock of the older sample is needed
  logic          hs_p, vs_p, bl_p;
  state_t        state;
  logic          line_err;
  logic [10:0]   x_cnt;
  logic [9:0]    y_cnt, y_nxt;
  logic [WW-1:0] wdog;

  logic strobe, hs_fall, vs_fall, act, act_end;
  logic wd_exp, line_bad, frame_bad, emit, drop;

  // Input sampling; idle levels (syncs high, clock high, blanked) on reset so
  // that reset release never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= '{1'b1, 1'b1, 1'b1, 1'b0, 24'h0};
      s2_pclk <= 1'b1;
    end else begin
      s1      <= '{vga_clk, vga_hs, vga_vs, vga_blank_n, {vga_r, vga_g, vga_b}};
      s2_pclk <= s1.pclk;
    end
  end

  assign strobe  = s1.pclk & ~s2_pclk;
  assign hs_fall = strobe & hs_p & ~s1.hs;
  assign vs_fall = strobe & vs_p & ~s1.vs;
  assign act     = strobe & s1.bl;
  assign act_end = strobe & bl_p & ~s1.bl;
  assign wd_exp  = (wdog == WW'(WDOG_CYCLES - 1));

  // Line count including a line ending on this same strobe, so a coincident
  // act_end is accounted for before the frame check.
  assign y_nxt     = (act_end && y_cnt != '1) ? y_cnt + 10'd1 : y_cnt;
  assign line_bad  = act_end & (x_cnt != 11'(H_ACTIVE));
  assign frame_bad = vs_fall & (y_nxt != 10'(V_ACTIVE));
  assign emit      = act & (state != SEARCH);
  assign drop      = (state == LOCKED) & (wd_exp | line_bad | frame_bad);

  // Strobe-domain history of the sync/blank levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_p <= 1'b1;
      vs_p <= 1'b1;
      bl_p <= 1'b0;
    end else if (strobe) begin
      hs_p <= s1.hs;
      vs_p <= s1.vs;
      bl_p <= s1.bl;
    end
  end

  // Coordinate counters and geometry latches. vs_fall clears both counters;
  // hs_fall clears x. Counters saturate instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt       <= '0;
      y_cnt       <= '0;
      line_px     <= '0;
      frame_lines <= '0;
    end else begin
      if (act_end) line_px <= x_cnt;
      if (vs_fall) begin
        frame_lines <= y_nxt;
        x_cnt       <= '0;
        y_cnt       <= '0;
      end else begin
        if (hs_fall)                x_cnt <= '0;
        else if (act && x_cnt != '1) x_cnt <= x_cnt + 11'd1;
        if (act_end) y_cnt <= y_nxt;
      end
    end
  end

  // Watchdog: counts clk cycles since the last hs_fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  wdog <= '0;
    else if (hs_fall || wd_exp) wdog <= '0;
    else                        wdog <= wdog + WW'(1);
  end

  // Lock state machine. Watchdog expiry and errors outrank the lock step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SEARCH;
      locked   <= 1'b0;
      line_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (drop && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (wd_exp) begin
        state  <= SEARCH;
        locked <= 1'b0;
      end else begin
        case (state)
          SEARCH: if (vs_fall) begin
            state    <= TRACK;
            line_err <= 1'b0;
          end
          TRACK: begin
            if (vs_fall) begin
              line_err <= 1'b0;
              if (!line_err && !line_bad && !frame_bad) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else if (line_bad) begin
              line_err <= 1'b1;
            end
          end
          LOCKED: if (line_bad || frame_bad) begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Pixel output; coordinates are the pre-increment counter values, and the
  // colour comes from the same sample as the strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_data  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
    end else begin
      pix_valid <= emit;
      pix_sof   <= emit & (x_cnt == 11'd0) & (y_cnt == 10'd0);
      pix_eol   <= emit & (x_cnt[9:0] == 10'(H_ACTIVE - 1));
      if (emit) begin
        pix_data <= s1.rgb;
        pix_x    <= x_cnt[9:0];
        pix_y    <= y_cnt;
      end
    end
  end

endmodule

// File: tb/tb_vga_rx.sv
module tb_vga_rx;
  localparam int H  = 16;
  localparam int V  = 8;
  localparam int WD = 256;
  localparam int M_SEARCH = 0, M_TRACK = 1, M_LOCK = 2;

  logic        clk = 1'b0, reset = 1'b1;
  logic        vga_clk = 1'b1, vga_hs = 1'b1, vga_vs = 1'b1, vga_blank_n = 1'b0;
  logic [7:0]  vga_r = '0, vga_g = '0, vga_b = '0;
  logic        pix_valid, pix_sof, pix_eol, locked;
  logic [23:0] pix_data;
  logic [9:0]  pix_x, pix_y, frame_lines;
  logic [10:0] line_px;
  logic [7:0]  err_cnt;

  int checks = 0, errors = 0;
  int n_valid = 0, n_sof = 0, n_eol = 0, n_pat = 0;

  always #10 clk = ~clk;

  vga_rx #(.H_ACTIVE(H), .V_ACTIVE(V), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .reset(reset), .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .locked(locked), .line_px(line_px),
    .frame_lines(frame_lines), .err_cnt(err_cnt)
  );

  // Reference model: works on the input history seen at each clk edge,
  // tracks coordinates and lock mode as plain integers and the watchdog as a
  // timestamp of its last clear.
  typedef struct packed {logic pclk, hs, vs, bl; logic [23:0] rgb;} smp_t;
  smp_t        p1, p2, cur, rst_s;
  int          mode, mx, my, lpx, flines, errc, cyc, last_clr;
  bit          hs_p, vs_p, bl_p, tbad;
  bit          e_valid, e_sof, e_eol;
  logic [23:0] e_data;
  int          e_x, e_y;

  initial begin : model
    bit st, hf, vf, a, ae, lbad, fbad, expired;
    rst_s = '{1'b1, 1'b1, 1'b1, 1'b0, 24'h0};
    cyc = 0;
    forever begin
      @(posedge clk);
      cur = '{vga_clk, vga_hs, vga_vs, vga_blank_n, {vga_r, vga_g, vga_b}};
      cyc++;
      if (reset) begin
        p1 = rst_s; p2 = rst_s;
        mode = M_SEARCH; mx = 0; my = 0; lpx = 0; flines = 0; errc = 0;
        hs_p = 1; vs_p = 1; bl_p = 0; tbad = 0; last_clr = cyc;
        e_valid = 0; e_sof = 0; e_eol = 0; e_data = '0; e_x = 0; e_y = 0;
      end else begin
        st = p1.pclk && !p2.pclk;
        expired = (cyc - last_clr) == WD;
        e_valid = 0; e_sof = 0; e_eol = 0;
        hf = 0; vf = 0; a = 0; ae = 0; lbad = 0; fbad = 0;
        if (st) begin
          hf = hs_p && !p1.hs;
          vf = vs_p && !p1.vs;
          a  = p1.bl;
          ae = bl_p && !p1.bl;
          hs_p = p1.hs; vs_p = p1.vs; bl_p = p1.bl;
        end
        if (a && mode != M_SEARCH) begin
          e_valid = 1; e_x = mx % 1024; e_y = my; e_data = p1.rgb;
          e_sof = (mx == 0 && my == 0);
          e_eol = (e_x == H - 1);
        end
        // line end first, then frame end
        if (ae) begin
          lpx = mx;
          lbad = (mx != H);
          if (my < 1023) my++;
        end
        if (vf) begin
          flines = my;
          fbad = (my != V);
        end
        if (vf) begin mx = 0; my = 0; end
        else if (hf) mx = 0;
        else if (a && mx < 2047) mx++;
        if (hf || expired) last_clr = cyc;
        if (expired) begin
          if (mode == M_LOCK && errc < 255) errc++;
          mode = M_SEARCH;
        end else if (mode == M_SEARCH) begin
          if (vf) begin mode = M_TRACK; tbad = 0; end
        end else if (mode == M_TRACK) begin
          if (lbad) tbad = 1;
          if (vf) begin
            if (!tbad && !fbad) mode = M_LOCK;
            tbad = 0;
          end
        end else if (lbad || fbad) begin
          mode = M_SEARCH;
          if (errc < 255) errc++;
        end
        p2 = p1; p1 = cur;
      end
      #1;
      checks++;
      if ({pix_valid, pix_sof, pix_eol, pix_data, pix_x, pix_y} !==
          {e_valid, e_sof, e_eol, e_data, 10'(e_x), 10'(e_y)}) begin
        errors++;
        $display("FAIL pix cyc %0d got v%0b s%0b e%0b d%06h x%0d y%0d want v%0b s%0b e%0b d%06h x%0d y%0d",
                 cyc, pix_valid, pix_sof, pix_eol, pix_data, pix_x, pix_y,
                 e_valid, e_sof, e_eol, e_data, e_x, e_y);
      end
      checks++;
      if ({locked, line_px, frame_lines, err_cnt} !==
          {mode == M_LOCK, 11'(lpx), 10'(flines), 8'(errc)}) begin
        errors++;
        $display("FAIL status cyc %0d got lk%0b lp%0d fl%0d ec%0d want lk%0b lp%0d fl%0d ec%0d",
                 cyc, locked, line_px, frame_lines, err_cnt, mode == M_LOCK, lpx, flines, errc);
      end
      if (pix_valid) n_valid++;
      if (pix_sof) n_sof++;
      if (pix_eol) n_eol++;
      if (pix_valid && pix_data !== {pix_x[7:0], pix_y[7:0], 8'h5A}) n_pat++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  // One pixel-clock period with random high/low widths of 1-2 clk.
  task automatic strobe(input logic hs, input logic vs, input logic bl, input logic [23:0] rgb);
    vga_clk = 1'b0; vga_hs = hs; vga_vs = vs; vga_blank_n = bl;
    {vga_r, vga_g, vga_b} = rgb;
    repeat ($urandom_range(1, 2)) @(negedge clk);
    vga_clk = 1'b1;
    repeat ($urandom_range(1, 2)) @(negedge clk);
  endtask

  task automatic line(input logic vs, input int nact, input int y, input bit pat);
    for (int i = 0; i < 3; i++) strobe(1'b0, vs, 1'b0, 24'($urandom));
    repeat ($urandom_range(1, 3)) strobe(1'b1, vs, 1'b0, 24'($urandom));
    for (int i = 0; i < nact; i++)
      strobe(1'b1, vs, 1'b1, pat ? {8'(i), 8'(y), 8'h5A} : 24'($urandom));
    repeat ($urandom_range(1, 3)) strobe(1'b1, vs, 1'b0, 24'($urandom));
  endtask

  task automatic frame(input int nlines, input int short_y, input int short_len, input bit pat);
    n_valid = 0; n_sof = 0; n_eol = 0; n_pat = 0;
    for (int i = 0; i < 2; i++) line(1'b0, 0, 0, pat);
    for (int i = 0; i < 2; i++) line(1'b1, 0, 0, pat);
    for (int y = 0; y < nlines; y++) line(1'b1, (y == short_y) ? short_len : H, y, pat);
    line(1'b1, 0, 0, pat);
  endtask

  initial begin : timeout
    repeat (90000) @(posedge clk);
    $display("FAIL timeout after 90000 cycles");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_outs_nonzero", int'(|{pix_valid, pix_sof, pix_eol, pix_data, pix_x, pix_y,
                                   line_px, frame_lines, err_cnt}), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Loopback with coordinate-coded colour
    frame(V, -1, 0, 1);
    chk("lb_locked_after_1vs", locked, 0);
    chk("lb_track_valid", n_valid, H * V);
    frame(V, -1, 0, 1);
    chk("lb_locked_after_2vs", locked, 1);
    frame(V, -1, 0, 1);
    chk("lb_valid", n_valid, H * V);
    chk("lb_sof", n_sof, 1);
    chk("lb_eol", n_eol, V);
    chk("lb_pattern_bad", n_pat, 0);
    chk("lb_line_px", line_px, H);
    chk("lb_frame_lines", frame_lines, V);
    chk("lb_err_cnt", err_cnt, 0);

    // Short line while locked
    frame(V, 3, H - 1, 0);
    chk("sl_valid", n_valid, 3 * H + H - 1);
    chk("sl_locked", locked, 0);
    chk("sl_err_cnt", err_cnt, 1);
    frame(V, -1, 0, 0);
    chk("sl_track_locked", locked, 0);
    frame(V, -1, 0, 0);
    chk("sl_relock", locked, 1);

    // Sync loss: strobes keep running, HS stays high
    repeat (200) strobe(1'b1, 1'b1, 1'b0, 24'($urandom));
    chk("sync_loss_locked", locked, 0);
    chk("sync_loss_err_cnt", err_cnt, 2);
    frame(V, -1, 0, 0);
    frame(V, -1, 0, 0);
    chk("sync_loss_relock", locked, 1);

    // Stopped pixel clock
    vga_clk = 1'b0;
    n_valid = 0;
    repeat (3000) @(negedge clk);
    chk("stop_valid", n_valid, 0);
    chk("stop_locked", locked, 0);
    chk("stop_err_cnt", err_cnt, 3);
    frame(V, -1, 0, 0);
    frame(V, -1, 0, 0);
    chk("stop_relock", locked, 1);

    // Reset in the middle of a frame
    for (int i = 0; i < 2; i++) line(1'b0, 0, 0, 0);
    for (int i = 0; i < 2; i++) line(1'b1, 0, 0, 0);
    for (int y = 0; y < 4; y++) line(1'b1, H, y, 0);
    #3 reset = 1'b1;
    #1;
    chk("midrst_locked", locked, 0);
    chk("midrst_outs_nonzero", int'(|{pix_valid, pix_sof, pix_eol, pix_data, pix_x, pix_y,
                                      line_px, frame_lines, err_cnt}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int y = 4; y < V; y++) line(1'b1, H, y, 0);
    line(1'b1, 0, 0, 0);
    chk("midrst_no_lock", locked, 0);
    frame(V, -1, 0, 0);
    chk("midrst_1vs", locked, 0);
    frame(V, -1, 0, 0);
    chk("midrst_2vs", locked, 1);
    chk("midrst_err_cnt", err_cnt, 0);

    // Short frame from a fresh reset
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int f = 0; f < 3; f++) frame(V - 1, -1, 0, 0);
    chk("sf_locked", locked, 0);
    chk("sf_track_valid", n_valid, H * (V - 1));
    chk("sf_frame_lines", frame_lines, V - 1);
    chk("sf_line_px", line_px, H);
    chk("sf_err_cnt", err_cnt, 0);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
